// File: rtl/r_inv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : r_inv_frame_sequencer
// Brief    : Per-frame start/capture/hold sequencer for the 2x2 R-inverse engine.
// Revision : 1.0 - initial release
// ============================================================================
module r_inv_frame_sequencer #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 11,
  parameter int FRAME_LEN   = 1026,
  parameter int START_CYC   = 0,
  parameter int TIMEOUT_CYC = 100,
  parameter int HOLD_END    = 1020
) (
  input  logic              I_sys_clk,
  input  logic              I_sys_rstn,
  input  logic              I_enable,
  input  logic [DATA_W-1:0] I_R11_inv,
  input  logic [DATA_W-1:0] I_R12_inv,
  input  logic [DATA_W-1:0] I_R21_inv,
  input  logic [DATA_W-1:0] I_R22_inv,
  input  logic              I_inv_done,
  input  logic              I_clr_err,
  output logic              O_inv_start,
  output logic [DATA_W-1:0] O_R11_inv_final,
  output logic [DATA_W-1:0] O_R12_inv_final,
  output logic [DATA_W-1:0] O_R21_inv_final,
  output logic [DATA_W-1:0] O_R22_inv_final,
  output logic              O_valid,
  output logic              O_timeout,
  output logic [7:0]        O_err_cnt,
  output logic [CNT_W-1:0]  O_frame_cnt,
  output logic [1:0]        O_state
);

  localparam logic [CNT_W-1:0] c_last    = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] c_start   = CNT_W'(START_CYC);
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] c_hold    = CNT_W'(HOLD_END);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  assign O_frame_cnt = r_cnt;
  assign O_state     = r_state;

  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      r_cnt <= '0;
    end else if (!I_enable) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      r_state         <= ST_IDLE;
      O_inv_start     <= 1'b0;
      O_R11_inv_final <= '0;
      O_R12_inv_final <= '0;
      O_R21_inv_final <= '0;
      O_R22_inv_final <= '0;
      O_valid         <= 1'b0;
      O_timeout       <= 1'b0;
      O_err_cnt       <= '0;
    end else begin
      O_inv_start <= 1'b0;
      // A timeout set later in this block overrides the clear.
      if (I_clr_err) begin
        O_timeout <= 1'b0;
      end
      if (!I_enable) begin
        r_state         <= ST_IDLE;
        O_R11_inv_final <= '0;
        O_R12_inv_final <= '0;
        O_R21_inv_final <= '0;
        O_R22_inv_final <= '0;
        O_valid         <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_cnt == c_start) begin
              O_inv_start <= 1'b1;
              r_state     <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (I_inv_done) begin
              O_R11_inv_final <= I_R11_inv;
              O_R12_inv_final <= I_R12_inv;
              O_R21_inv_final <= I_R21_inv;
              O_R22_inv_final <= I_R22_inv;
              O_valid         <= 1'b1;
              r_state         <= ST_HOLD;
            end else if (r_cnt == c_timeout) begin
              O_timeout <= 1'b1;
              if (O_err_cnt != 8'hFF) begin
                O_err_cnt <= O_err_cnt + 8'd1;
              end
              r_state <= ST_IDLE;
            end
          end
          ST_HOLD: begin
            if (r_cnt == c_hold) begin
              O_R11_inv_final <= '0;
              O_R12_inv_final <= '0;
              O_R21_inv_final <= '0;
              O_R22_inv_final <= '0;
              O_valid         <= 1'b0;
              r_state         <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_r_inv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_r_inv_frame_sequencer
// Brief    : Scoreboard bench for r_inv_frame_sequencer on a shortened frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_r_inv_frame_sequencer;

  localparam int P_DW    = 32;
  localparam int P_CW    = 8;
  localparam int P_FRAME = 128;
  localparam int P_START = 2;
  localparam int P_TO    = 20;
  localparam int P_HOLD  = 100;

  logic            clk;
  logic            sys_rstn;
  logic            enable;
  logic [P_DW-1:0] r11, r12, r21, r22;
  logic            inv_done;
  logic            clr_err;
  logic            O_inv_start;
  logic [P_DW-1:0] O_R11_inv_final, O_R12_inv_final, O_R21_inv_final, O_R22_inv_final;
  logic            O_valid;
  logic            O_timeout;
  logic [7:0]      O_err_cnt;
  logic [P_CW-1:0] O_frame_cnt;
  logic [1:0]      O_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4*P_DW-1:0] exp_q[$];
  logic [4*P_DW-1:0] last_exp;
  logic [4*P_DW-1:0] got;
  logic [4*P_DW-1:0] exp_v;

  r_inv_frame_sequencer #(
    .DATA_W(P_DW), .CNT_W(P_CW), .FRAME_LEN(P_FRAME),
    .START_CYC(P_START), .TIMEOUT_CYC(P_TO), .HOLD_END(P_HOLD)
  ) dut (
    .I_sys_clk(clk), .I_sys_rstn(sys_rstn), .I_enable(enable),
    .I_R11_inv(r11), .I_R12_inv(r12), .I_R21_inv(r21), .I_R22_inv(r22),
    .I_inv_done(inv_done), .I_clr_err(clr_err), .O_inv_start(O_inv_start),
    .O_R11_inv_final(O_R11_inv_final), .O_R12_inv_final(O_R12_inv_final),
    .O_R21_inv_final(O_R21_inv_final), .O_R22_inv_final(O_R22_inv_final),
    .O_valid(O_valid), .O_timeout(O_timeout), .O_err_cnt(O_err_cnt),
    .O_frame_cnt(O_frame_cnt), .O_state(O_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign got = {O_R11_inv_final, O_R12_inv_final, O_R21_inv_final, O_R22_inv_final};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int v);
    int k;
    k = 0;
    while (int'(O_frame_cnt) != v && k < 4 * P_FRAME) begin
      tick();
      k++;
    end
    if (int'(O_frame_cnt) != v) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_cnt: counter at %0d, required %0d", O_frame_cnt, v);
    end
  endtask

  task automatic drive_done(input logic [P_DW-1:0] a, b, c, d, input bit expect_capture);
    r11 = a; r12 = b; r21 = c; r22 = d;
    inv_done = 1'b1;
    if (expect_capture) exp_q.push_back({a, b, c, d});
    tick();
    inv_done = 1'b0;
    r11 = '0; r12 = '0; r21 = '0; r22 = '0;
  endtask

  task automatic test_reset();
    sys_rstn = 1'b0; enable = 1'b0; inv_done = 1'b0; clr_err = 1'b0;
    r11 = '0; r12 = '0; r21 = '0; r22 = '0;
    repeat (3) tick();
    n_tests++;
    if ({O_inv_start, O_valid, O_timeout, O_err_cnt, O_frame_cnt, O_state, got} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got start=%b valid=%b to=%b err=%0d cnt=%0d st=%0d finals=%h, required all 0",
               O_inv_start, O_valid, O_timeout, O_err_cnt, O_frame_cnt, O_state, got);
    end
    enable = 1'b1;
    sys_rstn = 1'b1;
    for (int k = 1; k <= P_START + 4; k++) begin
      tick();
      n_tests++;
      if ({O_frame_cnt, O_inv_start, O_state} !== {P_CW'(k), (k == P_START + 1), ((k >= P_START + 1) ? 2'd1 : 2'd0)}) begin
        n_fail++;
        $display("FAIL start_pulse k=%0d: got cnt=%0d start=%b st=%0d, required cnt=%0d start=%b st=%0d",
                 k, O_frame_cnt, O_inv_start, O_state, k, (k == P_START + 1), (k >= P_START + 1));
      end
    end
  endtask

  task automatic test_capture();
    wait_cnt(10);
    drive_done(32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
    n_tests++;
    exp_v = exp_q.pop_front();
    last_exp = exp_v;
    if ({O_valid, O_state, got} !== {1'b1, 2'd2, exp_v}) begin
      n_fail++;
      $display("FAIL capture: got valid=%b st=%0d finals=%h, required valid=1 st=2 finals=%h", O_valid, O_state, got, exp_v);
    end
    wait_cnt(P_HOLD);
    n_tests++;
    if ({O_valid, got} !== {1'b1, last_exp}) begin
      n_fail++;
      $display("FAIL hold_stable: got valid=%b finals=%h, required valid=1 finals=%h", O_valid, got, last_exp);
    end
    tick();
    n_tests++;
    if ({O_valid, O_state, got} !== '0) begin
      n_fail++;
      $display("FAIL hold_clear: got valid=%b st=%0d finals=%h, required all 0", O_valid, O_state, got);
    end
  endtask

  task automatic test_timeout();
    wait_cnt(P_TO);
    n_tests++;
    if ({O_timeout, O_state} !== {1'b0, 2'd1}) begin
      n_fail++;
      $display("FAIL pre_timeout: got to=%b st=%0d, required to=0 st=1", O_timeout, O_state);
    end
    tick();
    n_tests++;
    if ({O_timeout, O_err_cnt, O_state, O_valid, got} !== {1'b1, 8'd1, 2'd0, 1'b0, {4*P_DW{1'b0}}}) begin
      n_fail++;
      $display("FAIL timeout: got to=%b err=%0d st=%0d valid=%b finals=%h, required to=1 err=1 st=0 valid=0 finals=0",
               O_timeout, O_err_cnt, O_state, O_valid, got);
    end
    wait_cnt(P_FRAME - 1);
    tick();
    n_tests++;
    if (O_frame_cnt !== '0) begin
      n_fail++;
      $display("FAIL wrap: got cnt=%0d, required 0", O_frame_cnt);
    end
    wait_cnt(P_START + 1);
    n_tests++;
    if ({O_inv_start, O_state} !== {1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL restart: got start=%b st=%0d, required start=1 st=1", O_inv_start, O_state);
    end
    tick();
    n_tests++;
    if (O_inv_start !== 1'b0) begin
      n_fail++;
      $display("FAIL start_width: got start=%b, required 0", O_inv_start);
    end
  endtask

  task automatic test_coincident();
    wait_cnt(8);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_tests++;
    if (O_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err: got to=%b, required 0", O_timeout);
    end
    wait_cnt(P_TO);
    drive_done(32'd5, 32'd6, 32'd7, 32'hFFFF_FFFF, 1'b1);
    n_tests++;
    exp_v = exp_q.pop_front();
    last_exp = exp_v;
    if ({O_valid, O_timeout, O_err_cnt, got} !== {1'b1, 1'b0, 8'd1, exp_v}) begin
      n_fail++;
      $display("FAIL done_at_timeout: got valid=%b to=%b err=%0d finals=%h, required valid=1 to=0 err=1 finals=%h",
               O_valid, O_timeout, O_err_cnt, got, exp_v);
    end
  endtask

  task automatic test_stray_done();
    wait_cnt(50);
    drive_done(32'd9, 32'd9, 32'd9, 32'd9, 1'b0);
    n_tests++;
    if ({O_valid, O_state, O_err_cnt, got} !== {1'b1, 2'd2, 8'd1, last_exp}) begin
      n_fail++;
      $display("FAIL stray_hold: got valid=%b st=%0d err=%0d finals=%h, required valid=1 st=2 err=1 finals=%h",
               O_valid, O_state, O_err_cnt, got, last_exp);
    end
    wait_cnt(P_HOLD + 5);
    drive_done(32'd9, 32'd9, 32'd9, 32'd9, 1'b0);
    n_tests++;
    if ({O_valid, O_state, O_timeout, O_err_cnt, got} !== {1'b0, 2'd0, 1'b0, 8'd1, {4*P_DW{1'b0}}}) begin
      n_fail++;
      $display("FAIL stray_idle: got valid=%b st=%0d to=%b err=%0d finals=%h, required valid=0 st=0 to=0 err=1 finals=0",
               O_valid, O_state, O_timeout, O_err_cnt, got);
    end
  endtask

  task automatic test_reset_mid();
    wait_cnt(10);
    drive_done(32'hA, 32'hB, 32'hC, 32'hD, 1'b1);
    n_tests++;
    exp_v = exp_q.pop_front();
    if ({O_valid, got} !== {1'b1, exp_v}) begin
      n_fail++;
      $display("FAIL capture2: got valid=%b finals=%h, required valid=1 finals=%h", O_valid, got, exp_v);
    end
    wait_cnt(60);
    #2 sys_rstn = 1'b0;
    #1;
    n_tests++;
    if ({O_inv_start, O_valid, O_timeout, O_err_cnt, O_frame_cnt, O_state, got} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b to=%b err=%0d cnt=%0d st=%0d finals=%h, required all 0",
               O_valid, O_timeout, O_err_cnt, O_frame_cnt, O_state, got);
    end
    tick();
    sys_rstn = 1'b1;
  endtask

  task automatic test_disable();
    wait_cnt(P_TO + 1);
    n_tests++;
    if ({O_timeout, O_err_cnt} !== {1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL timeout_after_reset: got to=%b err=%0d, required to=1 err=1", O_timeout, O_err_cnt);
    end
    wait_cnt(15);
    enable = 1'b0;
    tick();
    n_tests++;
    if ({O_state, O_frame_cnt, O_inv_start, O_timeout, O_err_cnt} !== {2'd0, {P_CW{1'b0}}, 1'b0, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL disable: got st=%0d cnt=%0d start=%b to=%b err=%0d, required st=0 cnt=0 start=0 to=1 err=1",
               O_state, O_frame_cnt, O_inv_start, O_timeout, O_err_cnt);
    end
    drive_done(32'h1, 32'h1, 32'h1, 32'h1, 1'b0);
    repeat (4) tick();
    n_tests++;
    if ({O_valid, O_state, O_frame_cnt, O_inv_start, got} !== '0) begin
      n_fail++;
      $display("FAIL disabled_done: got valid=%b st=%0d cnt=%0d start=%b finals=%h, required all 0",
               O_valid, O_state, O_frame_cnt, O_inv_start, got);
    end
  endtask

  task automatic test_saturation();
    int exp_err;
    exp_err = 1;
    enable = 1'b1;
    for (int f = 0; f < 260; f++) begin
      wait_cnt(P_TO);
      if (f == 3) clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      if (exp_err < 255) exp_err++;
      n_tests++;
      if (O_err_cnt !== 8'(exp_err)) begin
        n_fail++;
        $display("FAIL err_cnt frame=%0d: got %0d, required %0d", f, O_err_cnt, exp_err);
      end
      if (f == 3) begin
        n_tests++;
        if (O_timeout !== 1'b1) begin
          n_fail++;
          $display("FAIL set_beats_clear: got to=%b, required 1", O_timeout);
        end
      end
    end
    wait_cnt(50);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_tests++;
    if ({O_timeout, O_err_cnt} !== {1'b0, 8'd255}) begin
      n_fail++;
      $display("FAIL clr_after_sat: got to=%b err=%0d, required to=0 err=255", O_timeout, O_err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_timeout();
    test_coincident();
    test_stray_done();
    test_reset_mid();
    test_disable();
    test_saturation();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d captures outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
